// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// Covers state and owner encodings plus the counter width.
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle between the two core ports, the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the core/memory environment.
interface mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arb_grant.sv
// Grant decision between fetch and data ports with a starvation guard.
// Data wins ties until fetch has lost STARVE_LIMIT grants in a row.
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    input  logic idle,
    output logic grant_if,
    output logic grant_d
);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic             starved;

    always_comb begin
        starved  = (starve_q == CNT_W'(STARVE_LIMIT));
        grant_if = idle & if_req & (~d_req | starved);
        grant_d  = idle & d_req & ~(if_req & starved);

        starve_d = starve_q;
        // Any cycle without a waiting fetch breaks the losing streak.
        if (grant_if || !if_req) begin
            starve_d = '0;
        end else if (grant_d && !starved) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port fixed-latency memory between instruction fetch and
// load/store, one transaction at a time through IDLE/ISSUE/WAIT/RESP.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.slave bus
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  lat_q, lat_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic idle;
    logic grant_if;
    logic grant_d;

    assign idle = (state_q == IDLE) & ~rst;

    mem_arb_grant #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_grant (
        .clk      (clk),
        .rst      (rst),
        .if_req   (bus.if_req),
        .d_req    (bus.d_req),
        .idle     (idle),
        .grant_if (grant_if),
        .grant_d  (grant_d)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lat_d      = lat_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    owner_d = OWN_D;
                    we_d    = bus.d_we;
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    state_d = ISSUE;
                end else if (grant_if) begin
                    owner_d = OWN_IF;
                    we_d    = 1'b0;
                    addr_d  = bus.if_addr;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                lat_d   = CNT_W'(MEM_LATENCY);
                state_d = WAIT;
            end
            WAIT: begin
                lat_d = lat_q - 1'b1;
                // mem_rdata is valid in the cycle the counter reaches 1.
                if (lat_q == CNT_W'(1)) begin
                    if (!we_q) begin
                        if (owner_q == OWN_D) begin
                            d_rdata_d = bus.mem_rdata;
                        end else begin
                            if_rdata_d = bus.mem_rdata;
                        end
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lat_q      <= lat_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // addr_q/wdata_q only change on the edge into ISSUE, so they double as
    // the held memory address and write data.
    assign bus.if_ready  = grant_if;
    assign bus.d_ready   = grant_d;
    assign bus.mem_en    = (state_q == ISSUE);
    assign bus.mem_we    = (state_q == ISSUE) & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_rvalid = (state_q == RESP) & (owner_q == OWN_IF);
    assign bus.d_rvalid  = (state_q == RESP) & (owner_q == OWN_D);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a latency-2 instance for most scenarios and a
// latency-1 instance, each backed by a fixed-latency memory model.
module tb_mem_arbiter;

    localparam int LAT_A = 2;
    localparam int LAT_B = 1;
    localparam int LIMIT = 4;
    localparam int PER_A = LAT_A + 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arb_if ia ();
    mem_arb_if ib ();

    mem_arbiter #(.MEM_LATENCY(LAT_A), .STARVE_LIMIT(LIMIT)) dut_a (
        .clk(clk), .rst(rst), .bus(ia.slave)
    );
    mem_arbiter #(.MEM_LATENCY(LAT_B), .STARVE_LIMIT(LIMIT)) dut_b (
        .clk(clk), .rst(rst), .bus(ib.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- memory device model ----------------
    logic [31:0] mdev   [0:63];
    bit          mvalid [0:63];
    logic [31:0] pipe_a [0:16];
    logic [31:0] pipe_b [0:16];
    logic [31:0] ref_mem [0:63];

    function automatic int midx(input logic [31:0] a);
        return int'({a[28], a[6:2]});
    endfunction

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'h8C080000;
        return 32'hA5000000 ^ (32'(i) * 32'h01010101);
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] a);
        return mvalid[midx(a)] ? mdev[midx(a)] : init_word(midx(a));
    endfunction

    // Data requested on mem_en reaches pipe[L] just before the edge ending
    // L cycles later; other stages carry junk so early/late capture shows.
    always @(negedge clk) begin
        for (int k = 1; k <= 16; k++) begin
            pipe_a[k] <= pipe_a[k-1];
            pipe_b[k] <= pipe_b[k-1];
        end
        pipe_a[0] <= $urandom;
        pipe_b[0] <= $urandom;
        if (ia.mem_en === 1'b1) begin
            if (ia.mem_we) begin
                mdev[midx(ia.mem_addr)]   <= ia.mem_wdata;
                mvalid[midx(ia.mem_addr)] <= 1'b1;
            end else begin
                pipe_a[0] <= mread(ia.mem_addr);
            end
        end
        if (ib.mem_en === 1'b1) begin
            if (ib.mem_we) begin
                mdev[midx(ib.mem_addr)]   <= ib.mem_wdata;
                mvalid[midx(ib.mem_addr)] <= 1'b1;
            end else begin
                pipe_b[0] <= mread(ib.mem_addr);
            end
        end
    end

    assign ia.mem_rdata = pipe_a[LAT_A];
    assign ib.mem_rdata = pipe_b[LAT_B];

    // ---------------- stimulus / observation helpers ----------------
    typedef struct packed {
        logic        if_ready;
        logic        d_ready;
        logic        if_rvalid;
        logic        d_rvalid;
        logic        mem_en;
        logic        mem_we;
        logic        busy;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] if_rdata;
        logic [31:0] d_rdata;
    } obs_t;

    function automatic obs_t obs(input bit sel);
        if (sel)
            return {ib.if_ready, ib.d_ready, ib.if_rvalid, ib.d_rvalid, ib.mem_en,
                    ib.mem_we, ib.busy, ib.mem_addr, ib.mem_wdata, ib.if_rdata, ib.d_rdata};
        return {ia.if_ready, ia.d_ready, ia.if_rvalid, ia.d_rvalid, ia.mem_en,
                ia.mem_we, ia.busy, ia.mem_addr, ia.mem_wdata, ia.if_rdata, ia.d_rdata};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_req(input bit sel, input bit is_d, input bit req, input bit we,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (!sel && is_d)  begin ia.d_req = req; ia.d_we = we; ia.d_addr = addr; ia.d_wdata = wdata; end
        if (!sel && !is_d) begin ia.if_req = req; ia.if_addr = addr; end
        if (sel && is_d)   begin ib.d_req = req; ib.d_we = we; ib.d_addr = addr; ib.d_wdata = wdata; end
        if (sel && !is_d)  begin ib.if_req = req; ib.if_addr = addr; end
    endtask

    // One complete transaction on one port; returns what was observed.
    task automatic xact(input bit sel, input bit is_d, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int acc_wait, output int en_off, output int en_cnt,
                        output bit en_we, output logic [31:0] en_addr,
                        output int rv_lat, output logic [31:0] rdata, output bit other_rv);
        obs_t o;
        acc_wait = -1; en_off = -1; en_cnt = 0; en_we = 1'b0; en_addr = '0;
        rv_lat = -1; rdata = '0; other_rv = 1'b0;
        drive_req(sel, is_d, 1'b1, we, addr, wdata);
        for (int k = 0; k < 60; k++) begin
            #1 o = obs(sel);
            if (is_d ? o.d_ready : o.if_ready) begin
                acc_wait = k;
                break;
            end
            tick();
        end
        tick();
        drive_req(sel, is_d, 1'b0, 1'b0, addr, wdata);
        if (acc_wait >= 0) begin
            for (int k = 1; k < 40; k++) begin
                #1 o = obs(sel);
                if (o.mem_en) begin
                    en_cnt++; en_off = k; en_we = o.mem_we; en_addr = o.mem_addr;
                end
                if (is_d ? o.if_rvalid : o.d_rvalid) other_rv = 1'b1;
                if (is_d ? o.d_rvalid : o.if_rvalid) begin
                    rv_lat = k;
                    rdata  = is_d ? o.d_rdata : o.if_rdata;
                    break;
                end
                tick();
            end
        end
        tick();
        $display("xact dut=%s port=%s %s addr=%h wdata=%h rdata=%h wait=%0d lat=%0d",
                 sel ? "B" : "A", is_d ? "D" : "IF", we ? "store" : "load",
                 addr, wdata, rdata, acc_wait, rv_lat);
    endtask

    logic [31:0] exp_if_rd;
    logic [31:0] exp_d_rd;
    int          acc_wait, en_off, en_cnt, rv_lat;
    bit          en_we, other_rv;
    logic [31:0] en_addr, rdata;

    // ---------------- scenarios ----------------
    task automatic test_reset();
        obs_t o;
        rst = 1'b1;
        drive_req(0, 0, 1'b1, 1'b0, 32'h00400000, '0);
        drive_req(0, 1, 1'b1, 1'b0, 32'h10008000, '0);
        tick();
        tick();
        #1 o = obs(0);
        n_checks++; if (o.busy !== 1'b0)      begin n_errors++; $display("FAIL reset_busy: got %b want 0", o.busy); end
        n_checks++; if (o.mem_en !== 1'b0)    begin n_errors++; $display("FAIL reset_mem_en: got %b want 0", o.mem_en); end
        n_checks++; if (o.mem_we !== 1'b0)    begin n_errors++; $display("FAIL reset_mem_we: got %b want 0", o.mem_we); end
        n_checks++; if ({o.if_rvalid, o.d_rvalid} !== 2'b00) begin n_errors++; $display("FAIL reset_rvalid: got %b want 00", {o.if_rvalid, o.d_rvalid}); end
        n_checks++; if ({o.if_ready, o.d_ready} !== 2'b00)   begin n_errors++; $display("FAIL reset_ready: got %b want 00", {o.if_ready, o.d_ready}); end
        n_checks++; if ({o.mem_addr, o.mem_wdata, o.if_rdata, o.d_rdata} !== 128'h0) begin
            n_errors++; $display("FAIL reset_regs: got %h %h %h %h want zeros", o.mem_addr, o.mem_wdata, o.if_rdata, o.d_rdata);
        end
        n_checks++; if (ib.busy !== 1'b0)     begin n_errors++; $display("FAIL reset_busy_b: got %b want 0", ib.busy); end
        drive_req(0, 0, 1'b0, 1'b0, '0, '0);
        drive_req(0, 1, 1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        tick();
        exp_if_rd = '0;
        exp_d_rd  = '0;
    endtask

    task automatic test_lone_fetch();
        obs_t o;
        xact(0, 0, 0, 32'h00400000, '0, acc_wait, en_off, en_cnt, en_we, en_addr, rv_lat, rdata, other_rv);
        n_checks++; if (acc_wait !== 0)  begin n_errors++; $display("FAIL fetch_accept_wait: got %0d want 0", acc_wait); end
        n_checks++; if (en_off !== 1 || en_cnt !== 1) begin n_errors++; $display("FAIL fetch_mem_en: got off=%0d cnt=%0d want off=1 cnt=1", en_off, en_cnt); end
        n_checks++; if (en_we !== 1'b0)  begin n_errors++; $display("FAIL fetch_mem_we: got %b want 0", en_we); end
        n_checks++; if (en_addr !== 32'h00400000) begin n_errors++; $display("FAIL fetch_mem_addr: got %h want 00400000", en_addr); end
        n_checks++; if (rv_lat !== LAT_A + 2) begin n_errors++; $display("FAIL fetch_latency: got %0d want %0d", rv_lat, LAT_A + 2); end
        n_checks++; if (rdata !== 32'h8C080000) begin n_errors++; $display("FAIL fetch_rdata: got %h want 8c080000", rdata); end
        n_checks++; if (other_rv !== 1'b0) begin n_errors++; $display("FAIL fetch_d_rvalid: got %b want 0", other_rv); end
        exp_if_rd = 32'h8C080000;
        #1 o = obs(0);
        n_checks++; if (o.d_rdata !== exp_d_rd) begin n_errors++; $display("FAIL fetch_d_rdata_iso: got %h want %h", o.d_rdata, exp_d_rd); end
    endtask

    task automatic test_store_load();
        obs_t o;
        xact(0, 1, 1, 32'h10008000, 32'hDEADBEEF, acc_wait, en_off, en_cnt, en_we, en_addr, rv_lat, rdata, other_rv);
        n_checks++; if (en_cnt !== 1 || en_we !== 1'b1) begin n_errors++; $display("FAIL store_strobe: got cnt=%0d we=%b want cnt=1 we=1", en_cnt, en_we); end
        n_checks++; if (rv_lat !== LAT_A + 2) begin n_errors++; $display("FAIL store_ack_latency: got %0d want %0d", rv_lat, LAT_A + 2); end
        n_checks++; if (rdata !== exp_d_rd) begin n_errors++; $display("FAIL store_d_rdata_kept: got %h want %h", rdata, exp_d_rd); end
        n_checks++; if (other_rv !== 1'b0) begin n_errors++; $display("FAIL store_if_rvalid: got %b want 0", other_rv); end
        ref_mem[midx(32'h10008000)] = 32'hDEADBEEF;
        #1 o = obs(0);
        n_checks++; if (o.mem_wdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL store_wdata_hold: got %h want deadbeef", o.mem_wdata); end
        xact(0, 1, 0, 32'h10008000, '0, acc_wait, en_off, en_cnt, en_we, en_addr, rv_lat, rdata, other_rv);
        n_checks++; if (en_we !== 1'b0) begin n_errors++; $display("FAIL load_mem_we: got %b want 0", en_we); end
        n_checks++; if (rdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL load_rdata: got %h want deadbeef", rdata); end
        exp_d_rd = 32'hDEADBEEF;
        #1 o = obs(0);
        n_checks++; if (o.if_rdata !== exp_if_rd) begin n_errors++; $display("FAIL load_if_rdata_iso: got %h want %h", o.if_rdata, exp_if_rd); end
    endtask

    task automatic test_contention();
        obs_t o;
        int   n = 0;
        int   nr = 0;
        bit   last_d = 1'b0;
        bit   exp_d;
        logic [31:0] fa = 32'h00400010;
        logic [31:0] da = 32'h10008010;
        drive_req(0, 0, 1'b1, 1'b0, fa, '0);
        drive_req(0, 1, 1'b1, 1'b0, da, '0);
        for (int c = 0; c < 150; c++) begin
            #1 o = obs(0);
            if (o.if_ready || o.d_ready) begin
                n_checks++; if (o.if_ready && o.d_ready) begin n_errors++; $display("FAIL cont_both_ready: got 11 want one-hot"); end
                exp_d = (n % (LIMIT + 1)) != LIMIT;
                n_checks++; if (o.d_ready !== exp_d) begin n_errors++; $display("FAIL cont_grant_%0d: got d=%b want d=%b", n, o.d_ready, exp_d); end
                last_d = o.d_ready;
                n++;
            end
            if (o.if_rvalid || o.d_rvalid) begin
                n_checks++; if (o.d_rvalid !== last_d || o.if_rvalid !== ~last_d) begin
                    n_errors++; $display("FAIL cont_resp_owner: got if=%b d=%b want d=%b", o.if_rvalid, o.d_rvalid, last_d);
                end
                n_checks++; if ((last_d ? o.d_rdata : o.if_rdata) !== ref_mem[midx(last_d ? da : fa)]) begin
                    n_errors++; $display("FAIL cont_rdata: got %h want %h", last_d ? o.d_rdata : o.if_rdata, ref_mem[midx(last_d ? da : fa)]);
                end
                nr++;
            end
            tick();
            if (n == 10) begin
                drive_req(0, 0, 1'b0, 1'b0, fa, '0);
                drive_req(0, 1, 1'b0, 1'b0, da, '0);
            end
            if (nr == 10) break;
        end
        n_checks++; if (n !== 10 || nr !== 10) begin n_errors++; $display("FAIL cont_count: got grants=%0d resps=%0d want 10/10", n, nr); end
        exp_if_rd = ref_mem[midx(fa)];
        exp_d_rd  = ref_mem[midx(da)];
        $display("contention: %0d grants, %0d responses", n, nr);
    endtask

    task automatic test_back_to_back();
        obs_t o;
        int   acc [3] = '{-1, -1, -1};
        int   n = 0;
        bit   exp_acc;
        bit   got_rv = 1'b0;
        drive_req(0, 1, 1'b1, 1'b0, 32'h10008020, '0);
        for (int c = 0; c < 60 && n < 3; c++) begin
            #1 o = obs(0);
            if (c <= 2 * PER_A) begin
                exp_acc = (c % PER_A) == 0;
                n_checks++; if (o.busy !== ~exp_acc || o.d_ready !== exp_acc) begin
                    n_errors++; $display("FAIL b2b_cycle_%0d: got busy=%b ready=%b want busy=%b ready=%b", c, o.busy, o.d_ready, ~exp_acc, exp_acc);
                end
            end
            if (o.d_ready) begin acc[n] = c; n++; end
            tick();
            if (o.d_ready) drive_req(0, 1, n < 3, 1'b0, 32'h10008020 + 32'(4 * n), '0);
        end
        n_checks++; if (acc[1] - acc[0] !== PER_A || acc[2] - acc[1] !== PER_A) begin
            n_errors++; $display("FAIL b2b_spacing: got %0d,%0d,%0d want spacing %0d", acc[0], acc[1], acc[2], PER_A);
        end
        for (int k = 0; k < 20; k++) begin
            #1 o = obs(0);
            if (o.d_rvalid) begin got_rv = 1'b1; tick(); break; end
            tick();
        end
        n_checks++; if (!got_rv || o.d_rdata !== ref_mem[midx(32'h10008028)]) begin
            n_errors++; $display("FAIL b2b_last_rdata: got rv=%b %h want %h", got_rv, o.d_rdata, ref_mem[midx(32'h10008028)]);
        end
        exp_d_rd = ref_mem[midx(32'h10008028)];
    endtask

    task automatic test_reset_mid_wait();
        obs_t o;
        drive_req(0, 0, 1'b1, 1'b0, 32'h00400020, '0);
        #1 o = obs(0);
        n_checks++; if (o.if_ready !== 1'b1) begin n_errors++; $display("FAIL rst_pre_accept: got %b want 1", o.if_ready); end
        tick();
        drive_req(0, 0, 1'b0, 1'b0, '0, '0);
        tick();
        rst = 1'b1;
        drive_req(0, 1, 1'b1, 1'b0, 32'h10008030, '0);
        #1 o = obs(0);
        n_checks++; if (o.d_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready_blocked: got %b want 0", o.d_ready); end
        tick();
        rst = 1'b0;
        #1 o = obs(0);
        n_checks++; if ({o.busy, o.mem_en, o.mem_we, o.if_rvalid, o.d_rvalid} !== 5'b0) begin
            n_errors++; $display("FAIL rst_mid_flags: got %b want 00000", {o.busy, o.mem_en, o.mem_we, o.if_rvalid, o.d_rvalid});
        end
        n_checks++; if ({o.mem_addr, o.mem_wdata, o.if_rdata, o.d_rdata} !== 128'h0) begin
            n_errors++; $display("FAIL rst_mid_regs: got %h %h %h %h want zeros", o.mem_addr, o.mem_wdata, o.if_rdata, o.d_rdata);
        end
        n_checks++; if (o.d_ready !== 1'b1) begin n_errors++; $display("FAIL rst_new_accept: got %b want 1", o.d_ready); end
        tick();
        drive_req(0, 1, 1'b0, 1'b0, '0, '0);
        for (int k = 1; k <= LAT_A + 2; k++) begin
            #1 o = obs(0);
            n_checks++; if (o.if_rvalid !== 1'b0) begin n_errors++; $display("FAIL rst_no_if_rvalid_%0d: got 1 want 0", k); end
            if (k == LAT_A + 2) begin
                n_checks++; if (o.d_rvalid !== 1'b1 || o.d_rdata !== ref_mem[midx(32'h10008030)]) begin
                    n_errors++; $display("FAIL rst_new_resp: got rv=%b %h want rv=1 %h", o.d_rvalid, o.d_rdata, ref_mem[midx(32'h10008030)]);
                end
            end
            tick();
        end
        exp_if_rd = '0;
        exp_d_rd  = ref_mem[midx(32'h10008030)];
    endtask

    task automatic test_random();
        obs_t        o;
        bit          is_d, we;
        logic [31:0] addr, wdata, want;
        for (int t = 0; t < 24; t++) begin
            is_d  = 1'($urandom_range(0, 1));
            we    = is_d & 1'($urandom_range(0, 1));
            addr  = (is_d ? 32'h10008040 : 32'h00400040) + 32'(4 * $urandom_range(0, 7));
            wdata = $urandom;
            want  = we ? exp_d_rd : ref_mem[midx(addr)];
            xact(0, is_d, we, addr, wdata, acc_wait, en_off, en_cnt, en_we, en_addr, rv_lat, rdata, other_rv);
            n_checks++; if (acc_wait !== 0 || en_off !== 1 || en_cnt !== 1) begin
                n_errors++; $display("FAIL rnd_%0d_timing: got wait=%0d off=%0d cnt=%0d want 0/1/1", t, acc_wait, en_off, en_cnt);
            end
            n_checks++; if (en_we !== we || en_addr !== addr) begin
                n_errors++; $display("FAIL rnd_%0d_strobe: got we=%b %h want we=%b %h", t, en_we, en_addr, we, addr);
            end
            n_checks++; if (rv_lat !== LAT_A + 2 || other_rv !== 1'b0) begin
                n_errors++; $display("FAIL rnd_%0d_resp: got lat=%0d other=%b want %0d/0", t, rv_lat, other_rv, LAT_A + 2);
            end
            n_checks++; if (rdata !== want) begin n_errors++; $display("FAIL rnd_%0d_rdata: got %h want %h", t, rdata, want); end
            if (we) ref_mem[midx(addr)] = wdata;
            if (is_d) exp_d_rd = want; else exp_if_rd = want;
            #1 o = obs(0);
            n_checks++; if ((is_d ? o.if_rdata : o.d_rdata) !== (is_d ? exp_if_rd : exp_d_rd)) begin
                n_errors++; $display("FAIL rnd_%0d_iso: got %h want %h", t, is_d ? o.if_rdata : o.d_rdata, is_d ? exp_if_rd : exp_d_rd);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic test_latency1();
        logic [31:0] fa = 32'h00400060;
        logic [31:0] da = 32'h10008060;
        xact(1, 0, 0, fa, '0, acc_wait, en_off, en_cnt, en_we, en_addr, rv_lat, rdata, other_rv);
        n_checks++; if (en_off !== 1 || rv_lat !== 3) begin n_errors++; $display("FAIL lat1_fetch_timing: got en=%0d rv=%0d want 1/3", en_off, rv_lat); end
        n_checks++; if (rdata !== ref_mem[midx(fa)]) begin n_errors++; $display("FAIL lat1_fetch_rdata: got %h want %h", rdata, ref_mem[midx(fa)]); end
        xact(1, 1, 1, da, 32'h0BADF00D, acc_wait, en_off, en_cnt, en_we, en_addr, rv_lat, rdata, other_rv);
        n_checks++; if (en_we !== 1'b1 || rv_lat !== 3) begin n_errors++; $display("FAIL lat1_store: got we=%b rv=%0d want 1/3", en_we, rv_lat); end
        ref_mem[midx(da)] = 32'h0BADF00D;
        xact(1, 1, 0, da, '0, acc_wait, en_off, en_cnt, en_we, en_addr, rv_lat, rdata, other_rv);
        n_checks++; if (rv_lat !== 3 || rdata !== 32'h0BADF00D) begin n_errors++; $display("FAIL lat1_load: got rv=%0d %h want 3 0badf00d", rv_lat, rdata); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        rst = 1'b1;
        ia.if_req = 1'b0; ia.if_addr = '0; ia.d_req = 1'b0; ia.d_we = 1'b0; ia.d_addr = '0; ia.d_wdata = '0;
        ib.if_req = 1'b0; ib.if_addr = '0; ib.d_req = 1'b0; ib.d_we = 1'b0; ib.d_addr = '0; ib.d_wdata = '0;
        test_reset();
        test_lone_fetch();
        test_store_load();
        test_contention();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        test_latency1();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
